// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core (C) and a DMA/debug engine (D) with
// wait-state handshake and access timeout. Define DMEM_ARB_FIXED_PRIO_EN for core-wins-ties.
module dmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              err,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic       OWN_C     = 1'b0;
  localparam logic       OWN_D     = 1'b1;
  localparam logic [7:0] TMO_LIM   = 8'(TMO_CYC);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_l_q, err_l_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
`ifdef DMEM_ARB_FIXED_PRIO_EN
`else
  logic              rr_q, rr_d;
`endif

  logic              c_gnt_q, c_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              c_done_q, c_done_d;
  logic              d_done_q, d_done_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              pick_d_s;
  logic [7:0]        cnt_inc_s;
  logic              own_s;

  // Winner selection: sole requester, otherwise the tie-break side.
  always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pick_d_s = d_req & ~c_req;
`else
    pick_d_s = d_req & (~c_req | rr_q);
`endif
  end

  assign cnt_inc_s = cnt_q + 8'd1;

  // Access sequencer: latch winner, wait for m_ready or timeout, one DONE cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_l_d   = err_l_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef DMEM_ARB_FIXED_PRIO_EN
`else
    rr_d      = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (c_req || d_req) begin
          state_d = ST_ACCESS;
          owner_d = pick_d_s;
          cnt_d   = 8'd0;
          err_l_d = 1'b0;
          if (pick_d_s) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = c_we;
            addr_d  = c_addr;
            wdata_d = c_wdata;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_inc_s;
        // m_ready wins over a timeout landing in the same cycle.
        if (m_ready) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = m_rdata;
            end else begin
              c_rdata_d = m_rdata;
            end
          end else begin
            c_rdata_d = c_rdata_q;
          end
        end else if (cnt_inc_s == TMO_LIM) begin
          state_d = ST_DONE;
          err_l_d = 1'b1;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        err_l_d = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
`else
        rr_d    = ~owner_q;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        err_l_d = 1'b0;
      end
    endcase
  end

  // Output flops are loaded from next-state so every port is a clean register.
  always_comb begin
    own_s     = (state_d == ST_ACCESS) || (state_d == ST_DONE);
    c_gnt_d   = own_s && (owner_d == OWN_C);
    d_gnt_d   = own_s && (owner_d == OWN_D);
    c_done_d  = (state_d == ST_DONE) && (owner_d == OWN_C);
    d_done_d  = (state_d == ST_DONE) && (owner_d == OWN_D);
    m_read_d  = (state_d == ST_ACCESS) && !we_d;
    m_write_d = (state_d == ST_ACCESS) && we_d;
    err_d     = (state_d == ST_DONE) && err_l_d;
    busy_d    = (state_d != ST_IDLE);
  end

  // State, latches and output registers; async reset abandons any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_C;
      we_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      cnt_q     <= 8'd0;
      err_l_q   <= 1'b0;
      c_rdata_q <= {DATA_W{1'b0}};
      d_rdata_q <= {DATA_W{1'b0}};
`ifdef DMEM_ARB_FIXED_PRIO_EN
`else
      rr_q      <= OWN_C;
`endif
      c_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      c_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_l_q   <= err_l_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef DMEM_ARB_FIXED_PRIO_EN
`else
      rr_q      <= rr_d;
`endif
      c_gnt_q   <= c_gnt_d;
      d_gnt_q   <= d_gnt_d;
      c_done_q  <= c_done_d;
      d_done_q  <= d_done_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign c_gnt   = c_gnt_q;
  assign d_gnt   = d_gnt_q;
  assign c_done  = c_done_q;
  assign d_done  = d_done_q;
  assign c_rdata = c_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected completions are queued when a request
// is driven and checked when the matching done pulse appears.
module tb_dmem_arbiter;

  typedef struct packed {
    logic       is_d;
    logic       err;
    logic [7:0] rdata;
  } sb_item_t;

  logic       clk;
  logic       rst;
  logic       c_req, c_we, d_req, d_we;
  logic [7:0] c_addr, c_wdata, d_addr, d_wdata;
  logic       c_gnt, c_done, d_gnt, d_done;
  logic [7:0] c_rdata, d_rdata;
  logic       m_read, m_write, m_ready;
  logic [7:0] m_addr, m_wdata, m_rdata;
  logic       err, busy;

  sb_item_t   sb_q[$];
  int         n_chk;
  int         n_fail;
  int         wait_n;
  logic       never_rdy;
  int         acc_cnt;
  logic [7:0] exp_c_rdata;
  logic [7:0] exp_d_rdata;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .TMO_CYC(15)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory responder: m_ready after wait_n wait cycles; read data = addr ^ 0x1C.
  always @(negedge clk) begin
    if (m_read || m_write) begin
      m_ready = !never_rdy && (acc_cnt == wait_n);
      m_rdata = m_ready ? (m_addr ^ 8'h1C) : 8'hEE;
      acc_cnt = acc_cnt + 1;
    end else begin
      m_ready = 1'b0;
      m_rdata = 8'hEE;
      acc_cnt = 0;
    end
  end

  // Completion monitor and mutual-exclusion checks.
  always @(negedge clk) begin
    sb_item_t it;
    if (rst) begin
      chk("gnt_excl", 32'(c_gnt & d_gnt), 32'd0);
      chk("strobe_excl", 32'(m_read & m_write), 32'd0);
      chk("err_without_done", 32'(err & ~(c_done | d_done)), 32'd0);
      if (c_done || d_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'({c_done, d_done}), 32'd0);
        end else begin
          it = sb_q.pop_front();
          chk("done_both", 32'(c_done & d_done), 32'd0);
          chk("done_owner", 32'(d_done), 32'(it.is_d));
          chk("done_err", 32'(err), 32'(it.err));
          chk("done_rdata", 32'(it.is_d ? d_rdata : c_rdata), 32'(it.rdata));
        end
      end
    end
  end

  task automatic do_access(input logic is_d, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata, input int waits, input logic never,
                           output int acc);
    sb_item_t it;
    int cyc;
    @(negedge clk);
    wait_n    = waits;
    never_rdy = never;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end
    it.is_d = is_d;
    it.err  = never;
    if (we || never) it.rdata = is_d ? exp_d_rdata : exp_c_rdata;
    else             it.rdata = addr ^ 8'h1C;
    if (is_d) exp_d_rdata = it.rdata;
    else      exp_c_rdata = it.rdata;
    sb_q.push_back(it);
    acc = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (m_read || m_write) acc++;
      chk("gnt_held", 32'(is_d ? d_gnt : c_gnt), 32'd1);
      if (cyc == 1) begin
        chk("m_addr_lat", 32'(m_addr), 32'(addr));
        chk("strobe_kind", 32'({m_read, m_write}), we ? 32'd1 : 32'd2);
        if (we) chk("m_wdata_lat", 32'(m_wdata), 32'(wdata));
      end
    end while (!(c_done || d_done) && cyc < 60);
    chk("done_seen", 32'(c_done | d_done), 32'd1);
    chk("latency", 32'(cyc), 32'(acc + 1));
    c_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    int acc;
    int cyc;
    int prev;
    int n;
    sb_item_t it;
    n_chk = 0; n_fail = 0;
    wait_n = 0; never_rdy = 1'b0; acc_cnt = 0;
    m_ready = 1'b0; m_rdata = 8'h00;
    exp_c_rdata = 8'h00; exp_d_rdata = 8'h00;
    c_req = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({c_gnt, d_gnt, c_done, d_done, m_read, m_write, err, busy}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 32'({c_gnt, d_gnt, c_done, d_done, m_read, m_write, err, busy}), 32'd0);
    chk("idle_rdata", 32'({c_rdata, d_rdata, m_addr}), 32'd0);

    // Core write, ready on first ACCESS cycle
    do_access(1'b0, 1'b1, 8'h10, 8'hA5, 0, 1'b0, acc);
    chk("t1_acc_cycles", 32'(acc), 32'd1);
    // DMA read with three wait cycles
    do_access(1'b1, 1'b0, 8'h20, 8'h00, 3, 1'b0, acc);
    chk("t2_acc_cycles", 32'(acc), 32'd4);
    // DMA write leaves d_rdata alone
    do_access(1'b1, 1'b1, 8'h7F, 8'h11, 1, 1'b0, acc);
    chk("dw_acc_cycles", 32'(acc), 32'd2);
    // Core read timeout
    do_access(1'b0, 1'b0, 8'h40, 8'h00, 0, 1'b1, acc);
    chk("tmo_acc_cycles", 32'(acc), 32'd15);
    // m_ready on the timeout cycle counts as success
    do_access(1'b0, 1'b0, 8'hFF, 8'h00, 14, 1'b0, acc);
    chk("edge_acc_cycles", 32'(acc), 32'd15);

    // Core read with address change and req drop mid-access
    @(negedge clk);
    wait_n = 2; never_rdy = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h44;
    it.is_d = 1'b0; it.err = 1'b0; it.rdata = 8'h44 ^ 8'h1C;
    exp_c_rdata = it.rdata;
    sb_q.push_back(it);
    @(negedge clk);
    c_addr = 8'h99; c_req = 1'b0;
    @(negedge clk);
    chk("t6_m_addr_kept", 32'(m_addr), 32'h44);
    n = 0;
    while (!c_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_done", 32'(c_done), 32'd1);

    // Asynchronous reset mid-access
    @(negedge clk);
    never_rdy = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h55;
    repeat (3) @(negedge clk);
    chk("t5_pre_read", 32'(m_read), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_drop", 32'({m_read, m_write, c_gnt, d_gnt, busy}), 32'd0);
    c_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    never_rdy = 1'b0;
    exp_c_rdata = 8'h00; exp_d_rdata = 8'h00;
    @(negedge clk);
    chk("t5_after_rst", 32'({c_gnt, d_gnt, c_done, d_done, busy, c_rdata, d_rdata}), 32'd0);
    chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // Both requesters held; pointer starts at C after reset
    @(negedge clk);
    wait_n = 0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h31;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      it.is_d = 1'b0;
`else
      it.is_d = (i % 2) == 1;
`endif
      it.err   = 1'b0;
      it.rdata = it.is_d ? (8'h31 ^ 8'h1C) : (8'h30 ^ 8'h1C);
      sb_q.push_back(it);
    end
    cyc = 0; prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        cyc++;
        n++;
      end while (!(c_done || d_done) && n < 20);
      chk("rr_done_seen", 32'(c_done | d_done), 32'd1);
      if (k > 0) chk("rr_period", 32'(cyc - prev), 32'd3);
      prev = cyc;
    end
    c_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
